// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared control definitions for the multicycle RV32I-subset
//               core: opcode constants, ALUOp encodings, datapath mux
//               encodings and the main-FSM state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    // Opcode field values of the supported instructions
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALUOp handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Main FSM states; encodings 11..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // True for any opcode the core implements
    function automatic logic is_known_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_main_fsm
// Description : Main control FSM of the multicycle RV32I-subset core
//               (lw, sw, R-type, I-type ALU, beq, jal). Sequences the shared
//               ALU, unified memory port and register file, stalls on the
//               memory-ready handshake and flags illegal opcodes.
// Ports       : clk, rst_n        - clock, async active-low reset
//               op, zero          - IR opcode field, ALU zero flag
//               mem_ready         - memory accepted/completed this cycle
//               mem_req, mem_write- memory request / write strobe
//               alu_op, alu_src_a, alu_src_b, result_src, adr_src
//                                 - datapath selects
//               ir_write, pc_write, reg_write
//                                 - datapath write strobes
//               illegal_instr     - pulse on unsupported opcode
//               instr_retired     - pulse on last cycle of an instruction
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W         = 4,   // must be >= 4 to hold all states
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal_instr,
    output logic       instr_retired
);

    localparam logic [STATE_W-1:0] c_fetch    = STATE_W'(S_FETCH);
    localparam logic [STATE_W-1:0] c_decode   = STATE_W'(S_DECODE);
    localparam logic [STATE_W-1:0] c_memadr   = STATE_W'(S_MEMADR);
    localparam logic [STATE_W-1:0] c_memread  = STATE_W'(S_MEMREAD);
    localparam logic [STATE_W-1:0] c_memwb    = STATE_W'(S_MEMWB);
    localparam logic [STATE_W-1:0] c_memwrite = STATE_W'(S_MEMWRITE);
    localparam logic [STATE_W-1:0] c_exec_r   = STATE_W'(S_EXEC_R);
    localparam logic [STATE_W-1:0] c_exec_i   = STATE_W'(S_EXEC_I);
    localparam logic [STATE_W-1:0] c_aluwb    = STATE_W'(S_ALUWB);
    localparam logic [STATE_W-1:0] c_beq      = STATE_W'(S_BEQ);
    localparam logic [STATE_W-1:0] c_jal      = STATE_W'(S_JAL);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;

    logic       w_mem_req;
    logic [1:0] w_alu_op;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_result_src;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_illegal;
    logic       w_retired;

    // ------------------------------------------------------------------
    // State register - the only flop in this block
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_fetch;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = c_fetch;
        case (r_state)
            c_fetch:    w_next = mem_ready ? c_decode : c_fetch;
            c_decode: begin
                case (op)
                    OP_LW, OP_SW: w_next = c_memadr;
                    OP_R:         w_next = c_exec_r;
                    OP_I:         w_next = c_exec_i;
                    OP_BEQ:       w_next = c_beq;
                    OP_JAL:       w_next = c_jal;
                    default:      w_next = c_fetch;
                endcase
            end
            c_memadr:   w_next = (op == OP_LW) ? c_memread : c_memwrite;
            c_memread:  w_next = mem_ready ? c_memwb : c_memread;
            c_memwb:    w_next = c_fetch;
            c_memwrite: w_next = mem_ready ? c_fetch : c_memwrite;
            c_exec_r:   w_next = c_aluwb;
            c_exec_i:   w_next = c_aluwb;
            c_aluwb:    w_next = c_fetch;
            c_beq:      w_next = c_fetch;
            c_jal:      w_next = c_aluwb;
            default:    w_next = c_fetch;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (ungated; reset gating applied below)
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_req    = 1'b0;
        w_alu_op     = ALUOP_ADD;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RS2;
        w_result_src = RES_ALUOUT;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_illegal    = 1'b0;
        w_retired    = 1'b0;
        case (r_state)
            c_fetch: begin
                // PC+4 computed while the instruction is read; IR/PC only
                // load once memory has delivered the word.
                w_mem_req    = 1'b1;
                w_src_a      = SRCA_PC;
                w_src_b      = SRCB_FOUR;
                w_alu_op     = ALUOP_ADD;
                w_result_src = RES_ALURESULT;
                w_adr_src    = 1'b0;
                w_ir_write   = mem_ready;
                w_pc_update  = mem_ready;
            end
            c_decode: begin
                // Speculative branch target OldPC+imm lands in ALUOut
                w_src_a   = SRCA_OLDPC;
                w_src_b   = SRCB_IMM;
                w_alu_op  = ALUOP_ADD;
                w_illegal = TRAP_ON_ILLEGAL && !is_known_op(op);
            end
            c_memadr: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_ADD;
            end
            c_memread: begin
                w_result_src = RES_ALUOUT;
                w_adr_src    = 1'b1;
                w_mem_req    = 1'b1;
            end
            c_memwb: begin
                w_result_src = RES_MEMDATA;
                w_reg_write  = 1'b1;
                w_retired    = 1'b1;
            end
            c_memwrite: begin
                w_result_src = RES_ALUOUT;
                w_adr_src    = 1'b1;
                w_mem_req    = 1'b1;
                w_mem_write  = mem_ready;
                w_retired    = mem_ready;
            end
            c_exec_r: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_RS2;
                w_alu_op = ALUOP_FUNCT;
            end
            c_exec_i: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            c_aluwb: begin
                w_result_src = RES_ALUOUT;
                w_reg_write  = 1'b1;
                w_retired    = 1'b1;
            end
            c_beq: begin
                // Result = ALUOut (branch target from DECODE) feeds the PC
                w_src_a      = SRCA_RS1;
                w_src_b      = SRCB_RS2;
                w_alu_op     = ALUOP_SUB;
                w_result_src = RES_ALUOUT;
                w_branch     = 1'b1;
                w_retired    = 1'b1;
            end
            c_jal: begin
                // PC <- target in ALUOut while ALU forms the link OldPC+4
                w_src_a      = SRCA_OLDPC;
                w_src_b      = SRCB_FOUR;
                w_alu_op     = ALUOP_ADD;
                w_result_src = RES_ALUOUT;
                w_pc_update  = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs are forced low combinationally while reset is held so that
    // an abandoned instruction cannot emit a write in the reset cycle.
    // ------------------------------------------------------------------
    assign mem_req       = rst_n & w_mem_req;
    assign alu_op        = {2{rst_n}} & w_alu_op;
    assign alu_src_a     = {2{rst_n}} & w_src_a;
    assign alu_src_b     = {2{rst_n}} & w_src_b;
    assign result_src    = {2{rst_n}} & w_result_src;
    assign adr_src       = rst_n & w_adr_src;
    assign ir_write      = rst_n & w_ir_write;
    assign pc_write      = rst_n & (w_pc_update | (w_branch & zero));
    assign reg_write     = rst_n & w_reg_write;
    assign mem_write     = rst_n & w_mem_write;
    assign illegal_instr = rst_n & w_illegal;
    assign instr_retired = rst_n & w_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_main_fsm
// Description : Directed self-checking bench for multicycle_main_fsm. Each
//               step drives inputs after a falling edge and compares the
//               packed control word one time unit later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal_instr;
    logic       instr_retired;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [6:0] c_lw   = 7'b0000011;
    localparam logic [6:0] c_sw   = 7'b0100011;
    localparam logic [6:0] c_r    = 7'b0110011;
    localparam logic [6:0] c_i    = 7'b0010011;
    localparam logic [6:0] c_beq  = 7'b1100011;
    localparam logic [6:0] c_jal  = 7'b1101111;
    localparam logic [6:0] c_bad  = 7'b1111111;

    multicycle_main_fsm #(
        .STATE_W        (4),
        .TRAP_ON_ILLEGAL(1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .alu_op       (alu_op),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .result_src   (result_src),
        .adr_src      (adr_src),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .illegal_instr(illegal_instr),
        .instr_retired(instr_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation:
    // {mem_req, alu_op, src_a, src_b, result_src, adr_src,
    //  ir_write, pc_write, reg_write, mem_write, illegal, retired}
    logic [15:0] w_obs;
    assign w_obs = {mem_req, alu_op, alu_src_a, alu_src_b, result_src, adr_src,
                    ir_write, pc_write, reg_write, mem_write, illegal_instr,
                    instr_retired};

    function automatic logic [15:0] mk(
        input logic       mreq,
        input logic [1:0] aop,
        input logic [1:0] sa,
        input logic [1:0] sb,
        input logic [1:0] rs,
        input logic       adr,
        input logic       irw,
        input logic       pcw,
        input logic       rw,
        input logic       mw,
        input logic       ill,
        input logic       ret
    );
        return {mreq, aop, sa, sb, rs, adr, irw, pcw, rw, mw, ill, ret};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, check settled outputs
    task automatic step(input logic [6:0] op_v, input logic z_v, input logic mr_v,
                        input string tag, input logic [15:0] exp);
        @(negedge clk);
        op        = op_v;
        zero      = z_v;
        mem_ready = mr_v;
        #1;
        chk(tag, w_obs, exp);
    endtask

    // Expected words per state
    logic [15:0] e_fetch_ok, e_fetch_wait, e_decode, e_memadr, e_memread, e_memwb;
    logic [15:0] e_mw_wait, e_mw_go, e_exec_r, e_exec_i, e_aluwb;
    logic [15:0] e_beq_t, e_beq_nt, e_jal, e_illegal;

    initial begin
        e_fetch_ok   = mk(1'b1, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e_fetch_wait = mk(1'b1, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_decode     = mk(1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_illegal    = mk(1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        e_memadr     = mk(1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_memread    = mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_memwb      = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        e_mw_wait    = mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_mw_go      = mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        e_exec_r     = mk(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_exec_i     = mk(1'b0, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_aluwb      = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        e_beq_t      = mk(1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        e_beq_nt     = mk(1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e_jal        = mk(1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- Reset: everything reads zero even with mem_ready high ----
        rst_n     = 1'b0;
        op        = 7'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("reset_outputs", w_obs, 16'h0000);

        // Release reset in FETCH with memory not yet ready: hold
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("fetch_wait", w_obs, e_fetch_wait);
        step(c_lw, 1'b0, 1'b0, "fetch_wait2", e_fetch_wait);

        // ---- lw, memory always ready: 5 cycles ----
        step(c_lw, 1'b0, 1'b1, "lw_fetch",   e_fetch_ok);
        step(c_lw, 1'b0, 1'b1, "lw_decode",  e_decode);
        step(c_lw, 1'b0, 1'b1, "lw_memadr",  e_memadr);
        step(c_lw, 1'b0, 1'b1, "lw_memread", e_memread);
        step(c_lw, 1'b0, 1'b1, "lw_memwb",   e_memwb);

        // ---- sw with 3 wait cycles in MEMWRITE ----
        step(c_sw, 1'b0, 1'b1, "sw_fetch",   e_fetch_ok);
        step(c_sw, 1'b0, 1'b1, "sw_decode",  e_decode);
        step(c_sw, 1'b0, 1'b0, "sw_memadr",  e_memadr);
        step(c_sw, 1'b0, 1'b0, "sw_wait1",   e_mw_wait);
        step(c_sw, 1'b0, 1'b0, "sw_wait2",   e_mw_wait);
        step(c_sw, 1'b0, 1'b0, "sw_wait3",   e_mw_wait);
        step(c_sw, 1'b0, 1'b1, "sw_write",   e_mw_go);

        // ---- beq taken ----
        step(c_beq, 1'b0, 1'b1, "beqt_fetch",  e_fetch_ok);
        step(c_beq, 1'b0, 1'b1, "beqt_decode", e_decode);
        step(c_beq, 1'b1, 1'b1, "beqt_beq",    e_beq_t);

        // ---- beq not taken ----
        step(c_beq, 1'b0, 1'b1, "beqn_fetch",  e_fetch_ok);
        step(c_beq, 1'b0, 1'b1, "beqn_decode", e_decode);
        step(c_beq, 1'b0, 1'b1, "beqn_beq",    e_beq_nt);

        // ---- R-type then jal back-to-back ----
        step(c_r, 1'b0, 1'b1, "r_fetch",    e_fetch_ok);
        step(c_r, 1'b0, 1'b1, "r_decode",   e_decode);
        step(c_r, 1'b0, 1'b1, "r_exec",     e_exec_r);
        step(c_r, 1'b0, 1'b1, "r_aluwb",    e_aluwb);
        step(c_jal, 1'b0, 1'b1, "jal_fetch",  e_fetch_ok);
        step(c_jal, 1'b0, 1'b1, "jal_decode", e_decode);
        step(c_jal, 1'b0, 1'b1, "jal_jal",    e_jal);
        step(c_jal, 1'b0, 1'b1, "jal_aluwb",  e_aluwb);

        // ---- I-type ALU ----
        step(c_i, 1'b0, 1'b1, "i_fetch",  e_fetch_ok);
        step(c_i, 1'b0, 1'b1, "i_decode", e_decode);
        step(c_i, 1'b0, 1'b1, "i_exec",   e_exec_i);
        step(c_i, 1'b0, 1'b1, "i_aluwb",  e_aluwb);

        // ---- Illegal opcode: pulse in DECODE, straight back to FETCH ----
        step(c_bad, 1'b0, 1'b1, "ill_fetch",  e_fetch_ok);
        step(c_bad, 1'b0, 1'b1, "ill_decode", e_illegal);
        step(c_bad, 1'b0, 1'b0, "ill_refetch", e_fetch_wait);

        // ---- Reset mid-MEMWRITE while memory is ready ----
        step(c_sw, 1'b0, 1'b1, "rst_fetch",  e_fetch_ok);
        step(c_sw, 1'b0, 1'b1, "rst_decode", e_decode);
        step(c_sw, 1'b0, 1'b0, "rst_memadr", e_memadr);
        step(c_sw, 1'b0, 1'b0, "rst_mw_wait", e_mw_wait);
        #1;
        mem_ready = 1'b1;
        #1;
        chk("rst_mw_ready", w_obs, e_mw_go);
        rst_n = 1'b0;
        #1;
        chk("rst_mw_killed", w_obs, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_after_release", w_obs, e_fetch_ok);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
